// File: rtl/sram6116_port_arbiter.sv
// Two-port arbiter in front of a single synchronous 2K x 8 SRAM macro.
// One access in flight at a time; round-robin or fixed-priority tie break.
module sram6116_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] LAT_INIT = 2'(RD_LATENCY - 1);

  state_t              state;
  state_t              next_state;
  logic                last_grant;
  logic                lat_we;
  logic [1:0]          lat_cnt;
  logic                any_req;
  logic                both_req;
  logic                winner;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // last_grant doubles as the identity of the port currently being served.
  always_comb begin
    any_req  = p0_req | p1_req;
    both_req = p0_req & p1_req;
    winner   = 1'b0;
    if (both_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (p1_req) begin
      winner = 1'b1;
    end
    win_we    = winner ? p1_we    : p0_we;
    win_addr  = winner ? p1_addr  : p0_addr;
    win_wdata = winner ? p1_wdata : p0_wdata;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = ISSUE;
      ISSUE:   next_state = lat_we ? ACK : WAIT;
      WAIT:    if (lat_cnt == 2'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_grant   <= 1'b1;
      lat_we       <= 1'b0;
      lat_cnt      <= 2'd0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      conflict_cnt <= '0;
    end else begin
      // The strobe is registered off the IDLE decision so it is high only in ISSUE.
      mem_en <= (state == IDLE) && any_req;
      mem_we <= (state == IDLE) && any_req && win_we;
      p0_ack <= (next_state == ACK) && !last_grant;
      p1_ack <= (next_state == ACK) && last_grant;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= winner;
            lat_we     <= win_we;
            mem_addr   <= win_addr;
            mem_wdata  <= win_wdata;
          end
          if (both_req && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + CNT_W'(1);
          end
        end
        ISSUE: lat_cnt <= LAT_INIT;
        WAIT: begin
          if (lat_cnt == 2'd0) begin
            if (last_grant) p1_rdata <= mem_rdata;
            else            p0_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram6116_port_arbiter.sv
// Directed bench for sram6116_port_arbiter: four parameterisations share one
// stimulus stream; a cycle table drives the default instance, sequences cover the rest.
module tb_sram6116_port_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [10:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  // Read-only SRAM model: fixed bytes at the addresses the vectors use.
  function automatic logic [7:0] modelByte(input logic [10:0] a);
    case (a)
      11'h123: return 8'h5A;
      11'h400: return 8'hC3;
      11'h7FF: return 8'h3C;
      default: return a[7:0] ^ 8'h96;
    endcase
  endfunction

  // Instance A: defaults
  logic a_p0_ack, a_p1_ack, a_mem_en, a_mem_we;
  logic [7:0] a_p0_rdata, a_p1_rdata, a_mem_wdata, a_mem_rdata;
  logic [10:0] a_mem_addr;
  logic [15:0] a_cnt;
  sram6116_port_arbiter dut_a (
    .ACLK(ACLK), .ARESET(ARESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .conflict_cnt(a_cnt));
  always @(posedge ACLK) a_mem_rdata <= (a_mem_en && !a_mem_we) ? modelByte(a_mem_addr) : 8'h00;

  // Instance B: fixed priority
  logic b_p0_ack, b_p1_ack, b_mem_en, b_mem_we;
  logic [7:0] b_p0_rdata, b_p1_rdata, b_mem_wdata, b_mem_rdata;
  logic [10:0] b_mem_addr;
  logic [15:0] b_cnt;
  sram6116_port_arbiter #(.FIXED_PRIO(1)) dut_b (
    .ACLK(ACLK), .ARESET(ARESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .conflict_cnt(b_cnt));
  always @(posedge ACLK) b_mem_rdata <= (b_mem_en && !b_mem_we) ? modelByte(b_mem_addr) : 8'h00;

  // Instance C: three-cycle read latency
  logic c_p0_ack, c_p1_ack, c_mem_en, c_mem_we;
  logic [7:0] c_p0_rdata, c_p1_rdata, c_mem_wdata, c_pipe0, c_pipe1, c_pipe2;
  logic [10:0] c_mem_addr;
  logic [15:0] c_cnt;
  sram6116_port_arbiter #(.RD_LATENCY(3)) dut_c (
    .ACLK(ACLK), .ARESET(ARESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(c_p0_ack), .p0_rdata(c_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(c_p1_ack), .p1_rdata(c_p1_rdata),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_rdata(c_pipe2), .conflict_cnt(c_cnt));
  always @(posedge ACLK) begin
    c_pipe0 <= (c_mem_en && !c_mem_we) ? modelByte(c_mem_addr) : 8'h00;
    c_pipe1 <= c_pipe0;
    c_pipe2 <= c_pipe1;
  end

  // Instance D: two-bit contention counter
  logic d_p0_ack, d_p1_ack, d_mem_en, d_mem_we;
  logic [7:0] d_p0_rdata, d_p1_rdata, d_mem_wdata, d_mem_rdata;
  logic [10:0] d_mem_addr;
  logic [1:0] d_cnt;
  sram6116_port_arbiter #(.CNT_W(2)) dut_d (
    .ACLK(ACLK), .ARESET(ARESET),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(d_p0_ack), .p0_rdata(d_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(d_p1_ack), .p1_rdata(d_p1_rdata),
    .mem_en(d_mem_en), .mem_we(d_mem_we), .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata),
    .mem_rdata(d_mem_rdata), .conflict_cnt(d_cnt));
  always @(posedge ACLK) d_mem_rdata <= (d_mem_en && !d_mem_we) ? modelByte(d_mem_addr) : 8'h00;

  typedef struct {
    logic        rst;
    logic        p0_req;
    logic        p0_we;
    logic [10:0] p0_addr;
    logic [7:0]  p0_wdata;
    logic        p1_req;
    logic        p1_we;
    logic [10:0] p1_addr;
    logic [7:0]  p1_wdata;
    logic        e_en;
    logic        e_we;
    logic [10:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_p0_ack;
    logic [7:0]  e_p0_rdata;
    logic        e_p1_ack;
    logic [7:0]  e_p1_rdata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input vec_t v);
    ARESET   = v.rst;
    p0_req   = v.p0_req;
    p0_we    = v.p0_we;
    p0_addr  = v.p0_addr;
    p0_wdata = v.p0_wdata;
    p1_req   = v.p1_req;
    p1_we    = v.p1_we;
    p1_addr  = v.p1_addr;
    p1_wdata = v.p1_wdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetAll();
    ARESET = 1'b1;
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge ACLK);
    ARESET = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ack_at;
    int en_cycles;
    int we_cycles;
    int p1_acks;
    int a0;
    int a1;
    int b0;
    int b1;
    logic [7:0] got;

    // Single write by p0, then single read by p1
    vecs.push_back('{1, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       0});
    vecs.push_back('{0, 1,1,11'h123,8'hA5,   0,0,0,0,             1,1,11'h123,8'hA5,   0,0,0,0,       0});
    vecs.push_back('{0, 1,1,11'h123,8'hA5,   0,0,0,0,             0,0,0,0,             1,0,0,0,       0});
    vecs.push_back('{0, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       0});
    vecs.push_back('{1, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       0});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h123,0,       1,0,11'h123,0,       0,0,0,0,       0});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h123,0,       0,0,0,0,             0,0,0,0,       0});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h123,0,       0,0,0,0,             0,0,1,8'h5A,   0});
    vecs.push_back('{0, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       0});
    // Dual requests with round-robin: p0, p1, p0, p1; p0 drops after its second ack
    vecs.push_back('{1, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       0});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       1,1,11'h000,8'h11,   0,0,0,0,       1});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             1,0,0,0,       1});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             0,0,0,0,       1});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       1,0,11'h7FF,0,       0,0,0,0,       2});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             0,0,0,0,       2});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             0,0,1,8'h3C,   2});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             0,0,0,0,       2});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       1,1,11'h000,8'h11,   0,0,0,0,       3});
    vecs.push_back('{0, 1,1,11'h000,8'h11,   1,0,11'h7FF,0,       0,0,0,0,             1,0,0,0,       3});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h7FF,0,       0,0,0,0,             0,0,0,0,       3});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h7FF,0,       1,0,11'h7FF,0,       0,0,0,0,       3});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h7FF,0,       0,0,0,0,             0,0,0,0,       3});
    vecs.push_back('{0, 0,0,0,0,             1,0,11'h7FF,0,       0,0,0,0,             0,0,1,8'h3C,   3});
    vecs.push_back('{0, 0,0,0,0,             0,0,0,0,             0,0,0,0,             0,0,0,0,       3});

    @(negedge ACLK);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge ACLK);
      checkOutput($sformatf("v%0d mem_en", i), 32'(a_mem_en), 32'(vecs[i].e_en));
      checkOutput($sformatf("v%0d mem_we", i), 32'(a_mem_we), 32'(vecs[i].e_we));
      if (vecs[i].e_en) checkOutput($sformatf("v%0d mem_addr", i), 32'(a_mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_en && vecs[i].e_we) checkOutput($sformatf("v%0d mem_wdata", i), 32'(a_mem_wdata), 32'(vecs[i].e_wdata));
      checkOutput($sformatf("v%0d p0_ack", i), 32'(a_p0_ack), 32'(vecs[i].e_p0_ack));
      checkOutput($sformatf("v%0d p1_ack", i), 32'(a_p1_ack), 32'(vecs[i].e_p1_ack));
      if (vecs[i].e_p0_ack) checkOutput($sformatf("v%0d p0_rdata", i), 32'(a_p0_rdata), 32'(vecs[i].e_p0_rdata));
      if (vecs[i].e_p1_ack) checkOutput($sformatf("v%0d p1_rdata", i), 32'(a_p1_rdata), 32'(vecs[i].e_p1_rdata));
      checkOutput($sformatf("v%0d conflict_cnt", i), 32'(a_cnt), 32'(vecs[i].e_cnt));
    end

    // Continuous dual requests: fixed priority starves p1, round-robin alternates
    resetAll();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'h000; p0_wdata = 8'h11;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'h7FF; p1_wdata = 8'h00;
    a0 = 0; a1 = 0; b0 = 0; b1 = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge ACLK);
      a0 += int'(a_p0_ack); a1 += int'(a_p1_ack);
      b0 += int'(b_p0_ack); b1 += int'(b_p1_ack);
    end
    checkOutput("fixed p0 grants", 32'(b0), 32'd3);
    checkOutput("fixed p1 grants", 32'(b1), 32'd0);
    checkOutput("fixed conflict_cnt", 32'(b_cnt), 32'd3);
    checkOutput("rr p0 grants", 32'(a0), 32'd2);
    checkOutput("rr p1 grants", 32'(a1), 32'd1);
    checkOutput("rr conflict_cnt", 32'(a_cnt), 32'd3);

    // Three-cycle read latency on instance C
    resetAll();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'h400;
    ack_at = -1; en_cycles = 0; we_cycles = 0; p1_acks = 0; got = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      en_cycles += int'(c_mem_en);
      we_cycles += int'(c_mem_we);
      p1_acks   += int'(c_p1_ack);
      if (c_p0_ack && ack_at < 0) begin
        ack_at = k;
        got    = c_p0_rdata;
        p0_req = 1'b0;
      end
    end
    checkOutput("lat3 ack cycle", 32'(ack_at), 32'd4);
    checkOutput("lat3 p0_rdata", 32'(got), 32'hC3);
    checkOutput("lat3 mem_en cycles", 32'(en_cycles), 32'd1);
    checkOutput("lat3 mem_we cycles", 32'(we_cycles), 32'd0);
    checkOutput("lat3 p1_ack count", 32'(p1_acks), 32'd0);

    // Reset asserted while instance A waits on a read
    resetAll();
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 11'h400;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 11'h123;
    @(negedge ACLK);
    checkOutput("rst-mid issue mem_en", 32'(a_mem_en), 32'd1);
    checkOutput("rst-mid issue cnt", 32'(a_cnt), 32'd1);
    @(negedge ACLK);
    ARESET = 1'b1;
    p1_req = 1'b0;
    #1;
    checkOutput("rst-mid async mem_addr", 32'(a_mem_addr), 32'd0);
    checkOutput("rst-mid async mem_en", 32'(a_mem_en), 32'd0);
    checkOutput("rst-mid async cnt", 32'(a_cnt), 32'd0);
    @(negedge ACLK);
    checkOutput("rst-mid held p0_ack", 32'(a_p0_ack), 32'd0);
    checkOutput("rst-mid held p1_ack", 32'(a_p1_ack), 32'd0);
    ARESET = 1'b0;
    ack_at = -1; got = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(negedge ACLK);
      if (a_p0_ack && ack_at < 0) begin
        ack_at = k;
        got    = a_p0_rdata;
        p0_req = 1'b0;
      end
    end
    checkOutput("reissue ack cycle", 32'(ack_at), 32'd2);
    checkOutput("reissue p0_rdata", 32'(got), 32'hC3);
    checkOutput("reissue cnt", 32'(a_cnt), 32'd0);

    // Saturation of the two-bit counter on instance D
    resetAll();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'h010; p0_wdata = 8'h01;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 11'h020; p1_wdata = 8'h02;
    for (int k = 0; k < 15; k++) @(negedge ACLK);
    checkOutput("sat cnt_w2", 32'(d_cnt), 32'd3);
    checkOutput("sat cnt_w16", 32'(a_cnt), 32'd5);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge ACLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
